// File: rtl/alu_iq_pkg.sv
// Shared types and constants for the ALU issue queue.
// Entry layout and issue-packet field offsets.
package alu_iq_pkg;

  localparam int ROB_W   = 5;
  localparam int PREG_W  = 6;
  localparam int PKT_W   = 18;
  localparam int ROB_LSB = 0;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 12;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rs1;
    logic              r1;
    logic [PREG_W-1:0] rs2;
    logic              r2;
  } iq_entry_t;

endpackage

// File: rtl/iq_pick_first.sv
// Lowest-index-set finder for issue select.
// Returns a one-hot grant and its binary index.
module iq_pick_first #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Compacting out-of-order ALU issue queue.
// Index 0 is oldest; issues the oldest fully-ready entry per cycle.
module alu_issue_scheduler
  import alu_iq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 2,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                       cpu_clock_i,
  input  logic                       cpu_resetn_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [ROB_W-1:0]           enq_rob_i,
  input  logic [PREG_W-1:0]          enq_rs1_i,
  input  logic                       enq_rs1_rdy_i,
  input  logic [PREG_W-1:0]          enq_rs2_i,
  input  logic                       enq_rs2_rdy_i,
  input  logic [WB_PORTS-1:0]        wb_valid_i,
  input  logic [PREG_W*WB_PORTS-1:0] wb_tag_i,
  output logic [PKT_W-1:0]           data_o,
  output logic                       valid_o,
  output logic [CW-1:0]              count_o
);

  iq_entry_t      q     [DEPTH];
  iq_entry_t      q_nxt [DEPTH];
  iq_entry_t      sh    [DEPTH];
  iq_entry_t      new_e;
  logic [CW-1:0]  count_nxt;
  logic [CW-1:0]  enq_pos;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] grant;
  logic [IW-1:0]  win;
  logic           any;
  logic           issue_fire;
  logic           enq_fire;
  logic [PKT_W-1:0] pkt;

  function automatic logic hit(
    input logic [PREG_W-1:0]          tag,
    input logic [WB_PORTS-1:0]        v,
    input logic [PREG_W*WB_PORTS-1:0] t
  );
    logic h;
    h = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (v[p] && t[p*PREG_W +: PREG_W] == tag) h = 1'b1;
    end
    return h;
  endfunction

  // Select sees only registered ready bits: a wakeup issues next cycle.
  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = q[i].valid & q[i].r1 & q[i].r2;
    end
  end

  iq_pick_first #(.N(DEPTH)) u_pick (
    .req    (cand),
    .onehot (grant),
    .idx    (win)
  );

  assign any         = |grant;
  assign enq_ready_o = (count_o != CW'(DEPTH));

  always_comb begin
    issue_fire = any & ~flush_i;
    enq_fire   = enq_valid_i & enq_ready_o & ~flush_i;
    enq_pos    = count_o - CW'(issue_fire);

    new_e.valid = 1'b1;
    new_e.rob   = enq_rob_i;
    new_e.rs1   = enq_rs1_i;
    new_e.r1    = enq_rs1_rdy_i | hit(enq_rs1_i, wb_valid_i, wb_tag_i);
    new_e.rs2   = enq_rs2_i;
    new_e.r2    = enq_rs2_rdy_i | hit(enq_rs2_i, wb_valid_i, wb_tag_i);

    sh[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      sh[i] = q[i+1];
    end

    for (int i = 0; i < DEPTH; i++) begin
      iq_entry_t e;
      e = (issue_fire && i >= int'(win)) ? sh[i] : q[i];
      if (e.valid) begin
        e.r1 = e.r1 | hit(e.rs1, wb_valid_i, wb_tag_i);
        e.r2 = e.r2 | hit(e.rs2, wb_valid_i, wb_tag_i);
      end
      if (enq_fire && enq_pos == CW'(i)) e = new_e;
      if (flush_i) e = '0;
      q_nxt[i] = e;
    end

    if (flush_i) count_nxt = '0;
    else count_nxt = count_o + CW'(enq_fire) - CW'(issue_fire);

    pkt = '0;
    pkt[ROB_LSB +: ROB_W]  = q[win].rob;
    pkt[RS1_LSB +: PREG_W] = q[win].rs1;
    pkt[RS2_LSB +: PREG_W] = q[win].rs2;
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count_o <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count_o <= count_nxt;
      valid_o <= issue_fire;
      if (issue_fire) data_o <= pkt;
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: vector table
// plus hand sequences for full, flush and async reset.
module tb_alu_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [4:0]  enq_rob;
  logic [5:0]  enq_rs1;
  logic        enq_rs1_rdy;
  logic [5:0]  enq_rs2;
  logic        enq_rs2_rdy;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [17:0] data;
  logic        valid;
  logic [3:0]  count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.DEPTH(8), .WB_PORTS(2)) dut (
    .cpu_clock_i   (clk),
    .cpu_resetn_i  (rst_n),
    .flush_i       (flush),
    .enq_valid_i   (enq_valid),
    .enq_ready_o   (enq_ready),
    .enq_rob_i     (enq_rob),
    .enq_rs1_i     (enq_rs1),
    .enq_rs1_rdy_i (enq_rs1_rdy),
    .enq_rs2_i     (enq_rs2),
    .enq_rs2_rdy_i (enq_rs2_rdy),
    .wb_valid_i    (wb_valid),
    .wb_tag_i      (wb_tag),
    .data_o        (data),
    .valid_o       (valid),
    .count_o       (count)
  );

  typedef struct {
    logic        ev;
    logic [4:0]  rob;
    logic [5:0]  rs1;
    logic        r1;
    logic [5:0]  rs2;
    logic        r2;
    logic [1:0]  wbv;
    logic [11:0] wbt;
    logic        fl;
    logic        xv;
    logic [17:0] xd;
    logic [3:0]  xc;
    logic        xr;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [17:0] pk(
    input logic [4:0] rob,
    input logic [5:0] rs1,
    input logic [5:0] rs2
  );
    return {rs2, rs1, 1'b0, rob};
  endfunction

  function automatic vec_t mk(
    input logic ev, input logic [4:0] rob,
    input logic [5:0] rs1, input logic r1,
    input logic [5:0] rs2, input logic r2,
    input logic [1:0] wbv, input logic [11:0] wbt,
    input logic xv, input logic [17:0] xd,
    input logic [3:0] xc
  );
    vec_t v;
    v.ev = ev; v.rob = rob;
    v.rs1 = rs1; v.r1 = r1;
    v.rs2 = rs2; v.r2 = r2;
    v.wbv = wbv; v.wbt = wbt;
    v.fl = 1'b0;
    v.xv = xv; v.xd = xd; v.xc = xc;
    v.xr = (xc != 4'd8);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic ev, input logic [4:0] rob,
    input logic [5:0] rs1, input logic r1,
    input logic [5:0] rs2, input logic r2,
    input logic [1:0] wbv, input logic [11:0] wbt,
    input logic fl
  );
    @(negedge clk);
    enq_valid = ev; enq_rob = rob;
    enq_rs1 = rs1; enq_rs1_rdy = r1;
    enq_rs2 = rs2; enq_rs2_rdy = r2;
    wb_valid = wbv; wb_tag = wbt;
    flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 12'd0, 0);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 0; enq_valid = 0; enq_rob = 0;
    enq_rs1 = 0; enq_rs1_rdy = 0;
    enq_rs2 = 0; enq_rs2_rdy = 0;
    wb_valid = 0; wb_tag = 0;

    tbl[0]  = mk(1, 3, 5, 1, 9, 1, 0, 0, 0, 18'd0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(3, 5, 9), 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(3, 5, 9), 0);
    tbl[3]  = mk(1, 1, 7, 0, 8, 1, 0, 0, 0, pk(3, 5, 9), 1);
    tbl[4]  = mk(1, 2, 4, 1, 6, 1, 0, 0, 0, pk(3, 5, 9), 2);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 4, 6), 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 12'd7, 0, pk(2, 4, 6), 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(1, 7, 8), 0);
    tbl[8]  = mk(1, 5, 10, 1, 12, 0, 2'b10, {6'd12, 6'd0},
                 0, pk(1, 7, 8), 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(5, 10, 12), 0);
    tbl[10] = mk(1, 6, 1, 1, 2, 1, 0, 0, 0, pk(5, 10, 12), 1);
    tbl[11] = mk(1, 7, 3, 1, 4, 1, 0, 0, 1, pk(6, 1, 2), 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(7, 3, 4), 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(7, 3, 4), 0);

    #12;
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_data", int'(data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", int'(enq_ready), 1);

    foreach (tbl[k]) begin
      drive(tbl[k].ev, tbl[k].rob, tbl[k].rs1, tbl[k].r1,
            tbl[k].rs2, tbl[k].r2, tbl[k].wbv, tbl[k].wbt,
            tbl[k].fl);
      edge1();
      chk($sformatf("v%0d_valid", k), int'(valid), int'(tbl[k].xv));
      chk($sformatf("v%0d_data", k), int'(data), int'(tbl[k].xd));
      chk($sformatf("v%0d_count", k), int'(count), int'(tbl[k].xc));
      chk($sformatf("v%0d_ready", k), int'(enq_ready), int'(tbl[k].xr));
    end

    // fill with 8 entries all blocked on tag 20
    for (int k = 0; k < 8; k++) begin
      drive(1, 5'(k), 6'd20, 0, 6'(30 + k), 1, 0, 0, 0);
      edge1();
    end
    chk("full_count", int'(count), 8);
    chk("full_ready", int'(enq_ready), 0);
    drive(1, 5'd31, 6'd1, 1, 6'd2, 1, 0, 0, 0);
    edge1();
    chk("full_noenq", int'(count), 8);
    chk("full_novalid", int'(valid), 0);
    drive(0, 0, 0, 0, 0, 0, 2'b01, 12'd20, 0);
    edge1();
    chk("wake_count", int'(count), 8);
    chk("wake_novalid", int'(valid), 0);
    for (int k = 0; k < 8; k++) begin
      idle();
      edge1();
      chk($sformatf("drain%0d_valid", k), int'(valid), 1);
      chk($sformatf("drain%0d_data", k), int'(data),
          int'(pk(5'(k), 6'd20, 6'(30 + k))));
      chk($sformatf("drain%0d_count", k), int'(count), 7 - k);
      chk($sformatf("drain%0d_ready", k), int'(enq_ready), 1);
    end
    idle();
    edge1();
    chk("drain_done", int'(valid), 0);

    // flush with one ready candidate and a same-cycle enqueue
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(10 + k), 6'd40, 0, 6'd41, 1, 0, 0, 0);
      edge1();
    end
    drive(1, 5'd13, 6'd42, 1, 6'd43, 1, 0, 0, 0);
    edge1();
    chk("pre_flush_count", int'(count), 4);
    drive(1, 5'd14, 6'd44, 1, 6'd45, 1, 0, 0, 1);
    edge1();
    chk("flush_count", int'(count), 0);
    chk("flush_valid", int'(valid), 0);
    chk("flush_ready", int'(enq_ready), 1);
    drive(0, 0, 0, 0, 0, 0, 2'b01, 12'd40, 0);
    edge1();
    chk("post_flush_valid", int'(valid), 0);
    chk("post_flush_count", int'(count), 0);

    // async reset mid-stream
    for (int k = 0; k < 5; k++) begin
      drive(1, 5'(20 + k), 6'd50, 0, 6'd51, 1, 0, 0, 0);
      edge1();
    end
    drive(1, 5'd25, 6'd52, 1, 6'd53, 1, 0, 0, 0);
    edge1();
    idle();
    edge1();
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_data", int'(data), int'(pk(5'd25, 6'd52, 6'd53)));
    chk("pre_rst_count", int'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_data", int'(data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'b01, 12'd50, 0);
    edge1();
    chk("fresh_novalid", int'(valid), 0);
    chk("fresh_count", int'(count), 0);
    drive(1, 5'd9, 6'd11, 1, 6'd13, 1, 0, 0, 0);
    edge1();
    chk("fresh_enq_count", int'(count), 1);
    chk("fresh_enq_valid", int'(valid), 0);
    idle();
    edge1();
    chk("fresh_issue_valid", int'(valid), 1);
    chk("fresh_issue_data", int'(data), int'(pk(5'd9, 6'd11, 6'd13)));
    chk("fresh_issue_count", int'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- Per-ALU out-of-order issue queue that sits in front of the ALU register-read/dispatch stage.
- Holds up to DEPTH renamed ALU micro-ops and tracks source-operand readiness from writeback tag broadcasts.
- Each cycle, issues the oldest fully-ready entry as the 18-bit {rs2, rs1, rsvd, rob} packet with a valid strobe.
- Opcode, immediate and destination are fetched downstream from instruction RAM via the ROB id, so they are not stored here.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 4..16).
- WB_PORTS, 2, number of writeback wakeup broadcast ports.

Ports:
- cpu_clock_i  input  1  core clock, all state on rising edge.
- cpu_resetn_i  input  1  asynchronous active-low reset.
- flush_i  input  1  pipeline flush; kills all queued and in-flight-issue state.
- enq_valid_i  input  1  dispatch offers a micro-op.
- enq_ready_o  output  1  queue can accept this cycle.
- enq_rob_i  input  5  ROB id.
- enq_rs1_i  input  6  physical source 1 tag.
- enq_rs1_rdy_i  input  1  source 1 already available.
- enq_rs2_i  input  6  physical source 2 tag.
- enq_rs2_rdy_i  input  1  source 2 already available (set by dispatch for immediate forms).
- wb_valid_i  input  WB_PORTS  wakeup broadcast valid per port.
- wb_tag_i  input  6*WB_PORTS  wakeup physical tag per port, port p at bits [6p+5:6p].
- data_o  output  18  issue packet: [4:0] rob, [5] reserved 0, [11:6] rs1, [17:12] rs2.
- valid_o  output  1  issue packet valid.
- count_o  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, cpu_resetn_i=0): all entry valid bits 0, count_o=0, valid_o=0, data_o=0. enq_ready_o=1 after deassertion.
- Storage is a compacting queue: index 0 is always the oldest. Each entry holds valid, rob, rs1, r1, rs2, r2.
- enq_ready_o = (count_o != DEPTH). It is registered-count based, so a slot freed by same-cycle issue is not reused until the next cycle.
- Enqueue fires when enq_valid_i & enq_ready_o & !flush_i. The new entry is written at position count_o, or count_o-1 if an issue also occurs this cycle (after compaction).
- Wakeup:
  - Each cycle, for every valid entry and every port p with wb_valid_i[p], a matching rs1 sets r1 and a matching rs2 sets r2.
  - Wakeup applies to the entry being enqueued in the same cycle as well: enqueued readiness = enq_rsX_rdy_i OR any tag match.
  - Tag 0 is not special.
- Select:
  - Candidates are valid & r1 & r2 using the registered ready bits.
  - An entry woken this cycle is issuable from the next cycle.
  - The lowest-index candidate is chosen.
- Issue:
  - When a candidate exists and !flush_i, on the next edge valid_o=1 and data_o={rs2, rs1, 1'b0, rob} of the winner.
  - Entries above the winner shift down one; count decrements.
  - No candidate → valid_o=0; data_o holds its last value.
- Latency: enqueue with both sources ready → valid_o asserted two edges after the enqueue edge (entry write edge, then issue edge). One issue per cycle maximum; downstream never back-pressures.
- Count update: count_next = count + enq_fire − issue_fire. Simultaneous enqueue and issue when full is impossible, because enq_ready_o=0.
- Flush: on a flush_i cycle, all entries are invalidated at the edge, count→0, valid_o→0, and any enqueue or issue in that cycle is dropped. enq_ready_o=1 the following cycle.
- Reset mid-operation: immediate clearing as above; no partial packet is emitted.
- Empty: no issue, count_o=0. Full: enq_ready_o=0, and wakeups and issue still operate.

Decomposition:
- Package alu_iq_pkg:
  - iq_entry_t struct {valid, rob[4:0], rs1[5:0], r1, rs2[5:0], r2}.
  - ROB_W=5, PREG_W=6.
  - Issue-packet field offset constants (ROB_LSB=0, RS1_LSB=6, RS2_LSB=12).
- One sub-module, iq_pick_first: a parameterised lowest-index-set one-hot/index finder used for the select. The rest stays in alu_issue_scheduler.

Test Plan:
- Reset then enqueue rob=3, rs1=5 ready, rs2=9 ready → valid_o=1 two edges later, data_o[4:0]=3, [11:6]=5, [17:12]=9, [5]=0; count_o returns to 0.
- Enqueue rob=1 (rs1=7 not ready), then rob=2 (both ready) → rob=2 issues first. wb_tag=7 → rob=1 issues on the cycle after the wakeup.
- Enqueue with rs2=12 not ready while wb_valid_i[1]=1 and wb_tag port1=12 in the same cycle → the entry is ready and issues next edge.
- Fill 8 entries, all blocked on tag 20 → enq_ready_o=0, count_o=8. Broadcast 20 → entries issue oldest-first, one per cycle, in enqueue order, with enq_ready_o=1 after the first issue edge.
- Hold 4 entries with one ready candidate, assert flush_i together with enq_valid_i → next cycle count_o=0, valid_o=0, no issue of either.
- Drop cpu_resetn_i asynchronously mid-stream with 5 entries → valid_o, count_o go to 0 immediately without a clock; after release the queue behaves as fresh.
